bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 114 +++++++++++
 tb/tb_bit_serializer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: MSB-first serializer for 1..8-bit frames with an
// optional idle gap after each frame.
//
// Parameters:
//   GAP        idle cycles after each frame (0..15)
//   IDLE_LEVEL level on out when no bit is being sent
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      frame request, taken when ready=1
//   data[7:0]  payload, captured on acceptance
//   len[3:0]   length in bits (0 or >8 means 8), captured on acceptance
//   ready      can accept start
//   busy       frame or gap in progress (~ready)
//   out        registered serial output
//   done       one-cycle pulse after a frame's last bit
//   remaining  bits still to send after the current one
module bit_serializer #(
    parameter int   GAP        = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    input  logic [3:0] len,
    output logic       ready,
    output logic       busy,
    output logic       out,
    output logic       done,
    output logic [3:0] remaining
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [3:0] GAP_W = 4'(GAP);

    logic [1:0] state;
    logic [7:0] sh;
    logic [3:0] rem;
    logic [3:0] gcnt;
    logic [3:0] eff_len;
    logic [7:0] aligned;
    logic       last;
    logic       accept;

    assign eff_len = (len == 4'd0 || len > 4'd8) ? 4'd8 : len;

    // Left-align the payload so the first bit is always at bit 7;
    // bits above L-1 fall off the top.
    assign aligned = data << (4'd8 - eff_len);

    assign last = (state == S_SHIFT) && (rem == 4'd0);

    // With no gap, the last-bit cycle also accepts a new frame so
    // consecutive frames run without an idle cycle between them.
    assign ready = (state == S_IDLE) || ((GAP == 0) && last);
    assign busy = ~ready;
    assign accept = start & ready;
    assign remaining = rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            sh    <= 8'd0;
            rem   <= 4'd0;
            gcnt  <= 4'd0;
            out   <= IDLE_LEVEL;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state <= S_SHIFT;
                out   <= aligned[7];
                sh    <= {aligned[6:0], 1'b0};
                rem   <= eff_len - 4'd1;
                // Back-to-back: the previous frame still ends here.
                if (last)
                    done <= 1'b1;
            end else begin
                unique case (state)
                    S_SHIFT: begin
                        if (rem == 4'd0) begin
                            done <= 1'b1;
                            out  <= IDLE_LEVEL;
                            if (GAP > 0) begin
                                state <= S_GAP;
                                gcnt  <= GAP_W - 4'd1;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            out <= sh[7];
                            sh  <= {sh[6:0], 1'b0};
                            rem <= rem - 4'd1;
                        end
                    end
                    S_GAP: begin
                        if (gcnt == 4'd0)
                            state <= S_IDLE;
                        else
                            gcnt <= gcnt - 4'd1;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed vectors for bit_serializer, one instance
// with GAP=1 and one with GAP=0 sharing the same stimulus.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data;
    logic [3:0] len;

    logic       rdy1, bsy1, out1, dn1;
    logic [3:0] rem1;
    logic       rdy0, bsy0, out0, dn0;
    logic [3:0] rem0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bit_serializer #(.GAP(1), .IDLE_LEVEL(1'b0)) u_g1 (
        .clk(clk), .rst(rst), .start(start), .data(data), .len(len),
        .ready(rdy1), .busy(bsy1), .out(out1), .done(dn1),
        .remaining(rem1)
    );

    bit_serializer #(.GAP(0), .IDLE_LEVEL(1'b0)) u_g0 (
        .clk(clk), .rst(rst), .start(start), .data(data), .len(len),
        .ready(rdy0), .busy(bsy0), .out(out0), .done(dn0),
        .remaining(rem0)
    );

    typedef struct {
        logic [7:0] d;
        logic [3:0] l;
        logic [7:0] bits;
        int         n;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int dcnt;
        rst = 1'b0;
        start = 1'b0;
        data = 8'h00;
        len = 4'd0;

        vecs[0] = '{d: 8'h07, l: 4'd5,  bits: 8'h07, n: 5};
        vecs[1] = '{d: 8'hA5, l: 4'd0,  bits: 8'hA5, n: 8};
        vecs[2] = '{d: 8'hA5, l: 4'd12, bits: 8'hA5, n: 8};
        vecs[3] = '{d: 8'hF3, l: 4'd3,  bits: 8'h03, n: 3};
        vecs[4] = '{d: 8'hFE, l: 4'd1,  bits: 8'h00, n: 1};
        vecs[5] = '{d: 8'h80, l: 4'd8,  bits: 8'h80, n: 8};

        // Reset with start high: no frame may begin.
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        data = 8'hFF;
        len = 4'd8;
        tick();
        chk("rst_out", out1, 0);
        chk("rst_ready", rdy1, 1);
        chk("rst_busy", bsy1, 0);
        chk("rst_done", dn1, 0);
        chk("rst_rem", rem1, 0);
        rst = 1'b0;
        start = 1'b0;
        tick();
        chk("rst_nostart_ready", rdy1, 1);
        chk("rst_nostart_out", out1, 0);

        // Frame table on the GAP=1 instance.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            start = 1'b1;
            data = vecs[v].d;
            len = vecs[v].l;
            tick();
            start = 1'b0;
            // Payload changes after acceptance must not leak in.
            data = ~vecs[v].d;
            len = 4'd2;
            for (int i = 0; i < vecs[v].n; i++) begin
                chk($sformatf("v%0d_bit%0d", v, i),
                    out1, vecs[v].bits[vecs[v].n - 1 - i]);
                chk($sformatf("v%0d_rem%0d", v, i),
                    rem1, vecs[v].n - 1 - i);
                chk($sformatf("v%0d_nodone%0d", v, i), dn1, 0);
                chk($sformatf("v%0d_busy%0d", v, i), bsy1, 1);
                tick();
            end
            chk($sformatf("v%0d_done", v), dn1, 1);
            chk($sformatf("v%0d_idle_out", v), out1, 0);
            chk($sformatf("v%0d_gap_ready", v), rdy1, 0);
            chk($sformatf("v%0d_gap_rem", v), rem1, 0);
            tick();
            chk($sformatf("v%0d_ready", v), rdy1, 1);
            chk($sformatf("v%0d_done_off", v), dn1, 0);
        end

        // Back-to-back on GAP=0: 101 then 11, start held.
        do_reset();
        start = 1'b1;
        data = 8'b101;
        len = 4'd3;
        tick();
        data = 8'b11;
        len = 4'd2;
        chk("b2b_o0", out0, 1);
        chk("b2b_r0", rem0, 2);
        tick();
        chk("b2b_o1", out0, 0);
        tick();
        chk("b2b_o2", out0, 1);
        chk("b2b_d2", dn0, 0);
        chk("b2b_rdy2", rdy0, 1);
        tick();
        start = 1'b0;
        chk("b2b_o3", out0, 1);
        chk("b2b_d3", dn0, 1);
        chk("b2b_r3", rem0, 1);
        tick();
        chk("b2b_o4", out0, 1);
        chk("b2b_d4", dn0, 0);
        tick();
        chk("b2b_d5", dn0, 1);
        chk("b2b_o5", out0, 0);
        chk("b2b_rdy5", rdy0, 1);
        tick();
        chk("b2b_d6", dn0, 0);
        chk("b2b_o6", out0, 0);

        // Start while busy is dropped, not queued.
        do_reset();
        start = 1'b1;
        data = 8'hC3;
        len = 4'd8;
        tick();
        start = 1'b0;
        dcnt = 0;
        for (int c = 1; c < 14; c++) begin
            start = (c == 2);
            data = 8'hFF;
            if (dn1)
                dcnt++;
            tick();
        end
        start = 1'b0;
        chk("busy_done_count", dcnt, 1);
        chk("busy_ready", rdy1, 1);
        chk("busy_out", out1, 0);

        // Abort mid-frame, then restart right after reset.
        do_reset();
        start = 1'b1;
        data = 8'hFF;
        len = 4'd8;
        tick();
        start = 1'b0;
        chk("abt_o0", out1, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abt_out", out1, 0);
        chk("abt_ready", rdy1, 1);
        chk("abt_done", dn1, 0);
        chk("abt_rem", rem1, 0);
        rst = 1'b0;
        start = 1'b1;
        data = 8'h01;
        len = 4'd1;
        tick();
        start = 1'b0;
        chk("abt_new_out", out1, 1);
        chk("abt_new_busy", bsy1, 1);
        chk("abt_new_nodone", dn1, 0);
        tick();
        chk("abt_new_done", dn1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
